// File: rtl/sandik_kilit.sv
// Sequential keypad safe: DIGITS-long code entry, retry counting, timed lockout, re-programming.
// Define SANDIK_THRESHOLD_EN to accept a digit when key >= stored digit instead of key == stored digit.
module sandik_kilit #(
  parameter int WIDTH       = 4,
  parameter int DIGITS      = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 8,
  parameter logic [WIDTH*DIGITS-1:0] RESET_CODE = 16'h1234
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [WIDTH-1:0]                   key,
  input  logic                               key_valid,
  input  logic                               clr,
  input  logic                               lock_cmd,
  input  logic                               prog,
  output logic                               open,
  output logic                               locked_out,
  output logic                               err,
  output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left
);

  localparam int CODE_W = WIDTH * DIGITS;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W  = $clog2(LOCK_CYCLES + 1);
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);

  // Handshake: key is consumed on every cycle key_valid=1; there is no backpressure.
  typedef enum logic [1:0] {
    S_CLOSED  = 2'd0,
    S_OPEN    = 2'd1,
    S_PROG    = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic                mismatch;
  logic [CODE_W-1:0]   code;
  logic [CODE_W-1:0]   shadow;
  logic [CODE_W-1:0]   shadow_next;
  logic [CNT_W-1:0]    lock_cnt;
  logic [WIDTH-1:0]    cur_digit;
  logic                digit_ok;
  logic                last_digit;

  // Digit 0 is the first entered and sits in the most significant slice.
  always_comb begin
    cur_digit   = '0;
    shadow_next = shadow;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit                                = code[WIDTH*(DIGITS-1-i) +: WIDTH];
        shadow_next[WIDTH*(DIGITS-1-i) +: WIDTH] = key;
      end
    end
  end

  assign last_digit = (idx == IDX_W'(DIGITS - 1));

`ifdef SANDIK_THRESHOLD_EN
  assign digit_ok = (key >= cur_digit);
`else
  assign digit_ok = (key == cur_digit);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_CLOSED;
      idx        <= '0;
      mismatch   <= 1'b0;
      code       <= RESET_CODE;
      shadow     <= RESET_CODE;
      lock_cnt   <= '0;
      tries_left <= TRY_W'(MAX_TRIES);
      open       <= 1'b0;
      locked_out <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_CLOSED: begin
          if (clr) begin
            idx      <= '0;
            mismatch <= 1'b0;
          end else if (key_valid) begin
            if (last_digit) begin
              idx      <= '0;
              mismatch <= 1'b0;
              if (!mismatch && digit_ok) begin
                state      <= S_OPEN;
                open       <= 1'b1;
                tries_left <= TRY_W'(MAX_TRIES);
              end else begin
                err <= 1'b1;
                // Saturate at zero; reaching zero starts the lockout immediately.
                if (tries_left <= TRY_W'(1)) begin
                  tries_left <= '0;
                  state      <= S_LOCKOUT;
                  locked_out <= 1'b1;
                  lock_cnt   <= CNT_W'(LOCK_CYCLES);
                end else begin
                  tries_left <= tries_left - 1'b1;
                end
              end
            end else begin
              idx      <= idx + 1'b1;
              mismatch <= mismatch | ~digit_ok;
            end
          end
        end

        S_LOCKOUT: begin
          if (lock_cnt <= CNT_W'(1)) begin
            state      <= S_CLOSED;
            locked_out <= 1'b0;
            tries_left <= TRY_W'(MAX_TRIES);
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end

        S_OPEN: begin
          if (lock_cmd) begin
            state    <= S_CLOSED;
            open     <= 1'b0;
            idx      <= '0;
            mismatch <= 1'b0;
          end else if (prog) begin
            state <= S_PROG;
            idx   <= '0;
          end
        end

        S_PROG: begin
          // Aborting leaves code untouched; shadow is rebuilt on the next programming run.
          if (lock_cmd) begin
            state    <= S_CLOSED;
            open     <= 1'b0;
            idx      <= '0;
            mismatch <= 1'b0;
          end else if (clr) begin
            state <= S_OPEN;
            idx   <= '0;
          end else if (key_valid) begin
            shadow <= shadow_next;
            if (last_digit) begin
              code  <= shadow_next;
              state <= S_OPEN;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        default: begin
          state <= S_CLOSED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sandik_kilit.sv
// Bench for sandik_kilit: a transaction-level reference model queues the expected outputs per cycle.
module tb_sandik_kilit;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int MT = 3;
  localparam int LC = 8;
  localparam int TW = $clog2(MT + 1);
  localparam int EW = TW + 3;
  localparam logic [W*D-1:0] RC = 16'h1234;

  logic          clk;
  logic          rst;
  logic [W-1:0]  key;
  logic          key_valid;
  logic          clr;
  logic          lock_cmd;
  logic          prog;
  logic          open;
  logic          locked_out;
  logic          err;
  logic [TW-1:0] tries_left;

  int n_assert = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  // reference model state
  int            m_state;  // 0 closed, 1 open, 2 prog, 3 lockout
  int            dig[$];
  int            sh[$];
  int            m_tries;
  int            m_cnt;
  logic [W*D-1:0] m_code;
  bit            m_open;
  bit            m_lo;
  bit            m_err;

  sandik_kilit #(
    .WIDTH(W), .DIGITS(D), .MAX_TRIES(MT), .LOCK_CYCLES(LC), .RESET_CODE(RC)
  ) dut (
    .clk(clk), .rst(rst), .key(key), .key_valid(key_valid), .clr(clr),
    .lock_cmd(lock_cmd), .prog(prog), .open(open), .locked_out(locked_out),
    .err(err), .tries_left(tries_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_assert++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, expv);
    end
  endtask

  function automatic int code_digit(input int i);
    return int'((m_code >> (W * (D - 1 - i))) & {{(W*D-W){1'b0}}, {W{1'b1}}});
  endfunction

  function automatic bit key_match(input int k, input int c);
`ifdef SANDIK_THRESHOLD_EN
    return k >= c;
`else
    return k == c;
`endif
  endfunction

  task automatic model_step(input bit r, input bit kv, input int k, input bit c,
                            input bit lk, input bit pg);
    bit ok;
    logic [W*D-1:0] nc;
    if (r) begin
      m_state = 0; dig.delete(); sh.delete();
      m_code = RC; m_tries = MT; m_cnt = 0;
      m_open = 0; m_lo = 0; m_err = 0;
      return;
    end
    m_err = 0;
    case (m_state)
      0: begin
        if (c) dig.delete();
        else if (kv) begin
          dig.push_back(k);
          if (dig.size() == D) begin
            ok = 1;
            for (int i = 0; i < D; i++) if (!key_match(dig[i], code_digit(i))) ok = 0;
            dig.delete();
            if (ok) begin
              m_state = 1; m_open = 1; m_tries = MT;
            end else begin
              m_err = 1;
              m_tries = m_tries - 1;
              if (m_tries == 0) begin
                m_state = 3; m_lo = 1; m_cnt = LC;
              end
            end
          end
        end
      end
      3: begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_state = 0; m_lo = 0; m_tries = MT;
        end
      end
      1: begin
        if (lk) begin
          m_state = 0; m_open = 0; dig.delete();
        end else if (pg) begin
          m_state = 2; sh.delete();
        end
      end
      default: begin
        if (lk) begin
          m_state = 0; m_open = 0; dig.delete();
        end else if (c) begin
          m_state = 1;
        end else if (kv) begin
          sh.push_back(k);
          if (sh.size() == D) begin
            nc = '0;
            for (int i = 0; i < D; i++) nc = (nc << W) | (W*D)'(sh[i]);
            m_code = nc;
            m_state = 1;
          end
        end
      end
    endcase
  endtask

  task automatic step(input bit r, input bit kv, input int k, input bit c,
                      input bit lk, input bit pg);
    @(negedge clk);
    rst = r; key_valid = kv; key = W'(k); clr = c; lock_cmd = lk; prog = pg;
    model_step(r, kv, k, c, lk, pg);
    exp_q.push_back({m_open, m_lo, m_err, TW'(m_tries)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic enter(input logic [W*D-1:0] c);
    for (int i = 0; i < D; i++) step(0, 1, int'(c[W*(D-1-i) +: W]), 0, 0, 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("open", 32'(open), 32'(mon_e[EW-1]));
      check("locked_out", 32'(locked_out), 32'(mon_e[EW-2]));
      check("err", 32'(err), 32'(mon_e[EW-3]));
      check("tries_left", 32'(tries_left), 32'(mon_e[TW-1:0]));
    end
  end

  initial begin
    int r;
    int k;
    rst = 1'b1; key = '0; key_valid = 1'b0; clr = 1'b0; lock_cmd = 1'b0; prog = 1'b0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(1);

    // correct code, wrong code, then correct again
    enter(16'h1234); idle(2); step(0, 0, 0, 0, 1, 0); idle(1);
    enter(16'h1235); idle(1); enter(16'h1234); idle(1); step(0, 0, 0, 0, 1, 0);

    // three back-to-back failures, keys during lockout are ignored
    enter(16'h1111); enter(16'h2222); enter(16'h0000);
    enter(16'h1234); enter(16'h1234); idle(2);
    enter(16'h1234); idle(1);

    // programming a new code
    step(0, 0, 0, 0, 0, 1); enter(16'h9876); idle(2);
    step(0, 0, 0, 0, 1, 0); enter(16'h1234); idle(1); enter(16'h9876); idle(1);

    // reset restores the default code; aborted programming keeps the old one
    step(1, 0, 0, 0, 0, 0); idle(1);
    enter(16'h1234); step(0, 0, 0, 0, 0, 1);
    step(0, 1, 5, 0, 0, 0); step(0, 1, 5, 0, 0, 0); step(0, 0, 0, 0, 1, 0);
    enter(16'h1234); idle(1);

    // clr aborting programming returns to open; lock_cmd beats prog
    step(0, 0, 0, 0, 0, 1); step(0, 1, 7, 0, 0, 0); step(0, 1, 7, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0); idle(1); step(0, 0, 0, 0, 1, 1); idle(1);
    enter(16'h1234); step(0, 0, 0, 0, 1, 0);

    // clr mid-entry consumes no attempt
    step(0, 1, 1, 0, 0, 0); step(0, 1, 2, 0, 0, 0); step(0, 1, 3, 1, 0, 0);
    enter(16'h1234); step(0, 0, 0, 0, 1, 0);

    // threshold-sensitive codes
    enter(16'h2345); idle(1); step(0, 0, 0, 0, 1, 0);
    enter(16'h0345); idle(1);

    // reset in the middle of a lockout
    step(1, 0, 0, 0, 0, 0);
    enter(16'h0000); enter(16'h0000); enter(16'h0000); idle(3);
    step(1, 0, 0, 0, 0, 0); enter(16'h1234); step(0, 0, 0, 0, 1, 0);

    // random traffic, guesses biased toward the stored digit
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (m_state == 0 && dig.size() < D && $urandom_range(0, 3) != 0)
        k = code_digit(dig.size());
      else
        k = $urandom_range(0, (1 << W) - 1);
      if (r == 0)      step(1, 0, 0, 0, 0, 0);
      else if (r < 65) step(0, 1, k, 0, 0, 0);
      else if (r < 69) step(0, $urandom_range(0, 1), k, 1, 0, 0);
      else if (r < 75) step(0, 0, 0, 0, 1, $urandom_range(0, 1));
      else if (r < 85) step(0, 0, 0, 0, 0, 1);
      else             step(0, 0, 0, 0, 0, 0);
    end

    idle(1);
    @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sandik_kilit.md
Name: sandik_kilit

Overview:
- Sequential, parametrised successor to the team's 2-bit combinational safe comparator.
- The operator enters a DIGITS-long code one digit per key strobe. The block compares each digit against a stored code and opens on a full match.
- Counts failed attempts and enforces a timed lockout.
- Allows re-programming the code while open. Sits between the keypad debouncer and the lock actuator driver.

Parameters:
- WIDTH, 4: bits per digit.
- DIGITS, 4: code length in digits (>=1).
- MAX_TRIES, 3: failed attempts allowed before lockout (>=1).
- LOCK_CYCLES, 8: lockout duration in clock cycles (>=1).
- RESET_CODE, 16'h1234: code after reset, WIDTH*DIGITS bits. Digit 0 (entered first) = MSB slice [WIDTH*DIGITS-1 -: WIDTH].

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- key  input  WIDTH  digit value, sampled when key_valid=1.
- key_valid  input  1  one-cycle digit strobe.
- clr  input  1  abort current entry/programming sequence.
- lock_cmd  input  1  close the safe.
- prog  input  1  start code programming (only honoured when open).
- open  output  1  safe open (OPEN or PROG state).
- locked_out  output  1  lockout active.
- err  output  1  one-cycle pulse on a failed attempt.
- tries_left  output  $clog2(MAX_TRIES+1)  remaining attempts.

Behaviour:
- Reset (one clk edge with rst=1):
  - state=CLOSED, idx=0, mismatch=0, code=RESET_CODE, tries_left=MAX_TRIES.
  - open=0, locked_out=0, err=0.
  - Reset mid-entry, mid-programming or mid-lockout discards everything and restores RESET_CODE.
- All outputs are registered.
- CLOSED:
  - On key_valid, the digit matches when key == code digit[idx].
  - mismatch accumulates by OR. idx increments.
  - No feedback is given per digit; evaluation happens only on the final digit.
- Final digit (idx==DIGITS-1 with key_valid):
  - All digits matched -> next cycle state=OPEN, open=1, tries_left=MAX_TRIES.
  - Any mismatch -> err=1 for exactly one cycle, tries_left decrements, idx and mismatch clear.
  - If tries_left becomes 0 -> LOCKOUT, locked_out=1 that same cycle.
- clr in CLOSED: idx=0, mismatch=0, no attempt consumed. clr takes priority over a simultaneous key_valid.
- LOCKOUT:
  - key_valid, clr, prog and lock_cmd are ignored.
  - Down-counter loads LOCK_CYCLES on entry. locked_out stays high exactly LOCK_CYCLES cycles.
  - Then state=CLOSED, tries_left=MAX_TRIES, locked_out=0.
- OPEN:
  - key_valid is ignored.
  - lock_cmd -> CLOSED (open=0 next cycle).
  - prog -> PROG with idx=0.
  - lock_cmd and prog in the same cycle: lock_cmd wins.
- PROG:
  - Each key_valid writes key into shadow digit[idx].
  - On the last digit the shadow is committed to code, state returns to OPEN.
  - lock_cmd or clr during PROG aborts: shadow is discarded, old code is kept. lock_cmd -> CLOSED; clr -> OPEN.
- Throughput: key_valid may be asserted every cycle. Back-to-back attempts are legal; the digit following a final digit starts a new attempt.
- Width rules:
  - idx width $clog2(DIGITS), minimum 1.
  - Lockout counter width $clog2(LOCK_CYCLES+1).
  - tries_left never underflows.

Optional Feature:
- Macro: SANDIK_THRESHOLD_EN.
- Defined: digit match is unsigned key >= code digit[idx], which is the generalised form of the original 2-bit T>=H safe. All other behaviour is unchanged.
- Undefined: match is exact equality.

Test Plan:
- Defaults, reset, keys 1,2,3,4 on consecutive cycles -> open=1 the cycle after the 4th strobe, err=0, tries_left=3.
- Keys 1,2,3,5 -> err pulses once, tries_left=2, open=0. Then 1,2,3,4 -> open=1, tries_left=3.
- Three wrong codes -> locked_out=1 for exactly 8 cycles, keys during lockout ignored. Afterwards tries_left=3 and the correct code opens.
- Open, prog, keys 9,8,7,6 -> code=16'h9876 and open stays 1. lock_cmd, then 1,2,3,4 fails (err=1), 9,8,7,6 opens.
- Open, prog, keys 5,5 then lock_cmd -> closed, code still 16'h1234. Also check clr mid-entry: keys 1,2 then clr, then 1,2,3,4 -> opens with tries_left=3.
- With SANDIK_THRESHOLD_EN: keys 2,3,4,5 against 16'h1234 -> open=1. Keys 0,3,4,5 -> err=1.
